multicycle_datapath: RTL
========================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MAX_WAIT, default 16, the maximum memory wait cycles before a bus timeout (range 1..255).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  32  fetch address (PC); imem_ready  in  1  fetch data valid; imem_rdata  in  32  instruction word.
REQ-005 SHALL have ports: dmem_req  out  1  data access request; dmem_we  out  1  1=store; dmem_addr  out  32  ALU result; dmem_wdata  out  32  rs2 data; dmem_ready  in  1  access complete; dmem_rdata  in  32  load data.
REQ-006 SHALL have ports: retire_valid  out  1  one-cycle retire pulse; retire_pc  out  32  PC of the retired instruction; retire_rd  out  5  destination register (0 if no write); retire_wdata  out  32  value written.
REQ-007 SHALL have ports: halted  out  1  ECALL/EBREAK reached; err  out  1  illegal opcode or bus timeout.

Function
REQ-008 SHALL execute RV32I (LUI, AUIPC, JAL, JALR, BRANCH, LOAD LW, STORE SW, OP-IMM, OP, SYSTEM) using an FSM with states FETCH, DECODE, EXECUTE, MEM, WB, HALT, ERROR.
REQ-009 In FETCH: SHALL assert imem_req with imem_addr=PC, hold both stable until imem_ready=1, latch imem_rdata into IR on that cycle, then go to DECODE.
REQ-010 In DECODE: SHALL read rs1/rs2 from the internal 32x32 register file into A/B registers and latch the sign-extended immediate; illegal opcode -> ERROR; SYSTEM -> HALT.
REQ-011 In EXECUTE: SHALL latch the ALU result; LOAD/STORE -> MEM; all others -> WB.
REQ-012 In MEM: SHALL assert dmem_req, with dmem_we=1 for stores, holding address and data stable until dmem_ready=1; loads latch dmem_rdata; then go to WB.
REQ-013 In WB: SHALL write rd when the instruction writes a register and rd!=0, pulse retire_valid for one cycle, update PC, and go to FETCH.
REQ-014 PC update: SHALL use PC+4 by default; a taken branch and JAL use PC+imm; JALR uses (rs1+imm) & ~1; JAL/JALR write PC+4 to rd.
REQ-015 Zero-wait latency: ALU/branch/jump = 4 cycles FETCH->FETCH; LW/SW = 5 cycles; each memory wait cycle adds 1 cycle.
REQ-016 Wait counter: SHALL clear on entry to FETCH/MEM and increment each cycle ready=0; reaching MAX_WAIT with ready still 0 -> ERROR.
REQ-017 x0 SHALL read 0 at all times; a write to x0 SHALL report retire_rd=0 and retire_wdata=0.
REQ-018 HALT and ERROR SHALL be absorbing until rst; in them all req outputs are 0, halted/err are 1 respectively, and no retire occurs.
REQ-019 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-020 Arithmetic SHALL be 32-bit with wrap-around; no overflow trap; misaligned addresses are passed through unchanged.

Reset
REQ-021 On rst=1 at a clock edge: state=FETCH, PC=RESET_PC, wait counter=0, IR=0, and every output=0 except imem_req (low during reset, high on the first cycle after reset).
REQ-022 Reset during a pending memory wait SHALL drop the request on the next cycle with no register-file write; register-file contents need not be cleared.

Structure
REQ-023 Package datapath_pkg SHALL hold the FSM state enum, the RV32I opcode constants, the ALU operation enum, and branch type codes.
REQ-024 Datapath and FSM SHALL be split out, with one sub-module mc_controller (FSM, wait counter, decode-driven control outputs) instantiated by multicycle_datapath.

Verification
REQ-025 IR=0x00500093 (addi x1,x0,5) with zero-wait imem -> retire_valid at the 4th cycle after reset, retire_rd=1, retire_wdata=5, next imem_addr=4.
REQ-026 x1=5 then 0x00102223 (sw x1,4(x0)) with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_addr=4, dmem_wdata=5, dmem_we=1, retire after 8 cycles total.
REQ-027 0x00000463 (beq x0,x0,8) at PC=0x10 -> retire_rd=0, next imem_addr=0x18; 0x0080006F (jal x0,8) at PC 0x18 -> next imem_addr=0x20.
REQ-028 imem_ready held 0 with MAX_WAIT=16 -> err=1 in the 17th cycle after reset, imem_req=0 thereafter; rst -> PC=RESET_PC, err=0.
REQ-029 0x00000073 (ecall) -> halted=1, no retire, all requests low; 0x0000007F (illegal) -> err=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared types, opcodes and helpers for the multicycle RV32I core.
// Holds FSM states, opcode constants, ALU op enum, branch codes, ALU/branch functions.
package datapath_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_HALT,
      S_ERROR
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_t;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   function automatic logic legal_op(input logic [6:0] op);
      return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                        OP_BRANCH, OP_LOAD, OP_STORE,
                        OP_IMM, OP_OP, OP_SYSTEM};
   endfunction

   // alt selects SUB/SRA; callers clear it where funct7 is not an opcode bit
   function automatic alu_op_t alu_dec(input logic [2:0] f3,
                                       input logic       alt);
      alu_op_t r;
      case (f3)
         3'b000:  r = alt ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = alt ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] alu(input alu_op_t     op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_SUB:  r = a - b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'b0, a < b};
         ALU_XOR:  r = a ^ b;
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = $signed(a) >>> b[4:0];
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         default:  r = a + b;
      endcase
      return r;
   endfunction

   function automatic logic br_taken(input logic [2:0]  f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      logic t;
      case (f3)
         BR_EQ:   t = (a == b);
         BR_NE:   t = (a != b);
         BR_LT:   t = ($signed(a) < $signed(b));
         BR_GE:   t = ($signed(a) >= $signed(b));
         BR_LTU:  t = (a < b);
         BR_GEU:  t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mc_controller.sv
// mc_controller: FSM, bus wait counter and per-state load enables.
// Ports: clk/rst, opcode from IR, imem/dmem ready in; load strobes, reqs, halted/err out.
module mc_controller
   import datapath_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       ir_ld,
   output logic       dec_ld,
   output logic       ex_ld,
   output logic       mdr_ld,
   output logic       wb_en,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       halted,
   output logic       err
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t     state;
   state_t     nxt;
   logic [7:0] wcnt;
   logic       timeout;
   logic       is_mem;

   assign is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
   assign timeout = (wcnt == WAIT_LAST);

   // Counter restarts on any state change, so it is zero on entry
   // to FETCH/MEM and only advances while a request goes unanswered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         wcnt  <= '0;
      end else begin
         state <= nxt;
         if (nxt != state)
            wcnt <= '0;
         else if (state == S_FETCH || state == S_MEM)
            wcnt <= wcnt + 8'd1;
      end
   end

   always_comb begin
      nxt    = state;
      ir_ld  = 1'b0;
      dec_ld = 1'b0;
      ex_ld  = 1'b0;
      mdr_ld = 1'b0;
      wb_en  = 1'b0;
      halted = 1'b0;
      err    = 1'b0;
      unique case (state)
         S_FETCH: begin
            if (imem_ready) begin
               ir_ld = 1'b1;
               nxt   = S_DECODE;
            end else if (timeout) begin
               nxt = S_ERROR;
            end
         end
         S_DECODE: begin
            dec_ld = 1'b1;
            if (!legal_op(opcode))
               nxt = S_ERROR;
            else if (opcode == OP_SYSTEM)
               nxt = S_HALT;
            else
               nxt = S_EXECUTE;
         end
         S_EXECUTE: begin
            ex_ld = 1'b1;
            nxt   = is_mem ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (dmem_ready) begin
               mdr_ld = (opcode == OP_LOAD);
               nxt    = S_WB;
            end else if (timeout) begin
               nxt = S_ERROR;
            end
         end
         S_WB: begin
            wb_en = !rst;
            nxt   = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         S_ERROR: err = 1'b1;
         default: nxt = S_ERROR;
      endcase
      imem_req = (state == S_FETCH) && !rst;
      dmem_req = (state == S_MEM) && !rst;
      dmem_we  = dmem_req && (opcode == OP_STORE);
   end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: RV32I multicycle core (PC, IR, regfile, ALU, bus muxes).
// Ports: clk/rst, imem fetch bus, dmem load/store bus, retire trace, halted/err.
module multicycle_datapath
   import datapath_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        retire_valid,
   output logic [31:0] retire_pc,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_wdata,
   output logic        halted,
   output logic        err
);

   logic [31:0] pc, ir, a_q, b_q, imm_q, alu_q, mdr;
   logic        taken_q;
   logic        ir_ld, dec_ld, ex_ld, mdr_ld, wb_en;
   logic [31:0] rf [32];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        is_lui, is_auipc, is_jal, is_jalr;
   logic        is_br, is_ld, is_st, is_imm, is_op;
   logic        rd_wr;
   logic [31:0] imm, opa, opb, pc4, npc, wdata;
   alu_op_t     op;

   assign opcode   = ir[6:0];
   assign rd       = ir[11:7];
   assign f3       = ir[14:12];
   assign rs1      = ir[19:15];
   assign rs2      = ir[24:20];
   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_br    = (opcode == OP_BRANCH);
   assign is_ld    = (opcode == OP_LOAD);
   assign is_st    = (opcode == OP_STORE);
   assign is_imm   = (opcode == OP_IMM);
   assign is_op    = (opcode == OP_OP);

   mc_controller #(
      .MAX_WAIT (MAX_WAIT)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .ir_ld      (ir_ld),
      .dec_ld     (dec_ld),
      .ex_ld      (ex_ld),
      .mdr_ld     (mdr_ld),
      .wb_en      (wb_en),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .halted     (halted),
      .err        (err)
   );

   always_comb begin
      imm = {{20{ir[31]}}, ir[31:20]};
      unique case (1'b1)
         is_lui, is_auipc:
            imm = {ir[31:12], 12'b0};
         is_jal:
            imm = {{11{ir[31]}}, ir[31], ir[19:12],
                   ir[20], ir[30:21], 1'b0};
         is_br:
            imm = {{19{ir[31]}}, ir[31], ir[7],
                   ir[30:25], ir[11:8], 1'b0};
         is_st:
            imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         default: ;
      endcase
   end

   // PC-relative targets go through the ALU; branch outcome is
   // latched separately so WB only has to pick a next PC.
   always_comb begin
      op  = ALU_ADD;
      opa = a_q;
      opb = imm_q;
      unique case (1'b1)
         is_lui: opa = '0;
         is_auipc, is_jal, is_br: opa = pc;
         is_op: begin
            opb = b_q;
            op  = alu_dec(f3, ir[30]);
         end
         is_imm: op = alu_dec(f3, (f3 == 3'b101) && ir[30]);
         default: ;
      endcase
   end

   assign pc4   = pc + 32'd4;
   assign rd_wr = (is_lui || is_auipc || is_jal || is_jalr ||
                   is_ld || is_imm || is_op) && (rd != 5'd0);
   assign wdata = (is_jal || is_jalr) ? pc4 :
                  is_ld ? mdr : alu_q;
   assign npc   = (is_jal || taken_q) ? alu_q :
                  is_jalr ? {alu_q[31:1], 1'b0} : pc4;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         ir      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         mdr     <= '0;
         taken_q <= 1'b0;
      end else begin
         if (ir_ld)
            ir <= imem_rdata;
         if (dec_ld) begin
            a_q   <= (rs1 == 5'd0) ? '0 : rf[rs1];
            b_q   <= (rs2 == 5'd0) ? '0 : rf[rs2];
            imm_q <= imm;
         end
         if (ex_ld) begin
            alu_q   <= alu(op, opa, opb);
            taken_q <= is_br && br_taken(f3, a_q, b_q);
         end
         if (mdr_ld)
            mdr <= dmem_rdata;
         if (wb_en)
            pc <= npc;
      end
   end

   always_ff @(posedge clk) begin
      if (wb_en && rd_wr)
         rf[rd] <= wdata;
   end

   assign imem_addr    = imem_req ? pc : '0;
   assign dmem_addr    = dmem_req ? alu_q : '0;
   assign dmem_wdata   = dmem_we ? b_q : '0;
   assign retire_valid = wb_en;
   assign retire_pc    = wb_en ? pc : '0;
   assign retire_rd    = (wb_en && rd_wr) ? rd : '0;
   assign retire_wdata = (wb_en && rd_wr) ? wdata : '0;

endmodule
